// File: rtl/seq_shift_rotator.sv
// ============================================================================
//  Module   : seq_shift_rotator
//  Purpose  : Command-driven shift/rotate engine, one single-bit step per clock
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_rotator #(
    parameter int                 WIDTH  = 8,
    parameter logic [WIDTH-1:0]   INIT   = {1'b1, {(WIDTH-1){1'b0}}},
    parameter int                 STEP_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [1:0]          cmd_mode,
    input  logic [STEP_W-1:0]   cmd_steps,
    output logic [WIDTH-1:0]    data_out,
    output logic                carry_out,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                carry_q, carry_d;
    logic [STEP_W-1:0]   rem_q, rem_d;
    logic                dir_q, dir_d;
    logic [1:0]          mode_q, mode_d;

    logic [WIDTH-1:0]    step_data;
    logic                step_carry;

    // Single-bit step of the current pattern using the latched command.
    always_comb begin
        step_carry = dir_q ? data_q[WIDTH-1] : data_q[0];
        case (mode_q)
            MODE_LSH: step_data = dir_q ? {data_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, data_q[WIDTH-1:1]};
            MODE_ASH: step_data = dir_q ? {data_q[WIDTH-2:0], 1'b0}
                                        : {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            default:  step_data = dir_q ? {data_q[WIDTH-2:0], data_q[WIDTH-1]}
                                        : {data_q[0], data_q[WIDTH-1:1]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        carry_d = carry_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    data_d  = load_data;
                    carry_d = 1'b0;
                end else if (cmd_valid) begin
                    dir_d   = cmd_dir;
                    mode_d  = cmd_mode;
                    rem_d   = cmd_steps;
                    state_d = (cmd_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                data_d  = step_data;
                carry_d = step_carry;
                rem_d   = rem_q - STEP_W'(1);
                if (rem_q == STEP_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= INIT;
            carry_q <= 1'b0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
        end
    end

    // A load in IDLE takes priority, so it withholds ready for that cycle.
    assign cmd_ready = (state_q == ST_IDLE) && !load;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign data_out  = data_q;
    assign carry_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_rotator.sv
// ============================================================================
//  Module   : tb_seq_shift_rotator
//  Purpose  : Self-checking bench for seq_shift_rotator (8-bit configuration)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_rotator;

    localparam int         W      = 8;
    localparam int         SW     = 8;
    localparam logic [7:0] INIT_V = 8'h80;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [W-1:0]  load_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [1:0]    cmd_mode;
    logic [SW-1:0] cmd_steps;
    logic [W-1:0]  data_out;
    logic          carry_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_data;
    logic       m_carry;

    seq_shift_rotator #(
        .WIDTH  (W),
        .INIT   (INIT_V),
        .STEP_W (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_mode  (cmd_mode),
        .cmd_steps (cmd_steps),
        .data_out  (data_out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pattern after k steps, computed directly from the shift/rotate definitions.
    function automatic logic [7:0] after_k(input logic [7:0] d, input logic dir,
                                           input logic [1:0] mode, input int k);
        logic signed [7:0] s;
        int r;
        s = d;
        if (mode == 2'b01 || (mode == 2'b10 && dir)) begin
            if (k >= W) return 8'h00;
            return dir ? (d << k) : (d >> k);
        end else if (mode == 2'b10) begin
            if (k >= W) return {8{d[7]}};
            return s >>> k;
        end
        r = k % W;
        if (r == 0) return d;
        return dir ? ((d << r) | (d >> (W - r))) : ((d >> r) | (d << (W - r)));
    endfunction

    function automatic logic carry_k(input logic [7:0] d, input logic dir,
                                     input logic [1:0] mode, input int k);
        logic [7:0] v;
        v = after_k(d, dir, mode, k - 1);
        return dir ? v[7] : v[0];
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy,      1'b0);
        chk({tag, "_done"},  done,      1'b0);
        chk({tag, "_ready"}, cmd_ready, 1'b1);
        chk({tag, "_data"},  data_out,  m_data);
        chk({tag, "_carry"}, carry_out, m_carry);
    endtask

    task automatic do_load(input logic [7:0] v);
        load      = 1'b1;
        load_data = v;
        #1;
        chk("load_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        load = 1'b0;
        m_data  = v;
        m_carry = 1'b0;
        #1;
        chk_idle("load");
    endtask

    // Issue one command at a negedge in IDLE and follow it cycle by cycle.
    task automatic do_cmd(input logic dir, input logic [1:0] mode, input int n,
                          input string tag);
        chk({tag, "_ready_pre"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_mode  = mode;
        cmd_steps = n[SW-1:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        if (n == 0) begin
            chk({tag, "_z_done"}, done, 1'b1);
            chk({tag, "_z_busy"}, busy, 1'b0);
            chk({tag, "_z_data"}, data_out, m_data);
            chk({tag, "_z_ready"}, cmd_ready, 1'b0);
        end else begin
            chk({tag, "_busy0"}, busy, 1'b1);
            chk({tag, "_ready0"}, cmd_ready, 1'b0);
            for (int i = 1; i <= n; i++) begin
                // Disturb inputs while running; none of it may take effect.
                cmd_valid = 1'($urandom);
                cmd_dir   = 1'($urandom);
                cmd_mode  = 2'($urandom);
                cmd_steps = 8'($urandom);
                load      = 1'($urandom);
                load_data = 8'($urandom);
                @(negedge clk);
                chk({tag, "_data"},  data_out,  after_k(m_data, dir, mode, i));
                chk({tag, "_carry"}, carry_out, carry_k(m_data, dir, mode, i));
                chk({tag, "_busy"},  busy,      (i < n) ? 1'b1 : 1'b0);
                chk({tag, "_done"},  done,      (i == n) ? 1'b1 : 1'b0);
            end
            load      = 1'b0;
            cmd_valid = 1'b0;
            m_carry = carry_k(m_data, dir, mode, n);
            m_data  = after_k(m_data, dir, mode, n);
        end
        @(negedge clk);
        chk_idle({tag, "_end"});
    endtask

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_steps = '0;
        m_data    = INIT_V;
        m_carry   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", data_out, 8'h80);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_idle("reset_idle");

        do_cmd(1'b1, 2'b00, 3, "rol3");
        chk("rol3_lit", data_out, 8'h04);
        chk("rol3_carry_lit", carry_out, 1'b0);

        do_load(8'h90);
        do_cmd(1'b0, 2'b10, 2, "asr2");
        chk("asr2_lit", data_out, 8'hE4);

        do_load(8'hA5);
        do_cmd(1'b1, 2'b01, 3, "lsl3");
        chk("lsl3_lit", data_out, 8'h28);
        chk("lsl3_carry_lit", carry_out, 1'b1);

        do_cmd(1'b1, 2'b00, 0, "zero");

        do_load(8'h3C);
        do_cmd(1'b0, 2'b00, 8, "ror8");
        chk("ror8_lit", data_out, 8'h3C);

        do_load(8'hFF);
        do_cmd(1'b1, 2'b01, 9, "lsl9");
        chk("lsl9_lit", data_out, 8'h00);

        // Load and command in the same cycle: load wins, command follows.
        load      = 1'b1;
        load_data = 8'h5A;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_mode  = 2'b11;
        cmd_steps = 8'd2;
        #1;
        chk("race_ready", cmd_ready, 1'b0);
        @(negedge clk);
        load = 1'b0;
        m_data  = 8'h5A;
        m_carry = 1'b0;
        #1;
        chk("race_data", data_out, 8'h5A);
        chk("race_busy", busy, 1'b0);
        chk("race_done", done, 1'b0);
        do_cmd(1'b1, 2'b11, 2, "race_cmd");

        // Reset during the second step of a 5-step command.
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_mode  = 2'b00;
        cmd_steps = 8'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("abort_step1", data_out, after_k(m_data, 1'b1, 2'b00, 1));
        rst_n = 1'b0;
        #1;
        chk("abort_data",  data_out,  8'h80);
        chk("abort_busy",  busy,      1'b0);
        chk("abort_done",  done,      1'b0);
        chk("abort_carry", carry_out, 1'b0);
        m_data  = INIT_V;
        m_carry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone_rst", done, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_nodone", done, 1'b0);
        end
        chk_idle("abort_idle");

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) do_load(8'($urandom));
            do_cmd(1'($urandom), 2'($urandom), int'($urandom_range(0, 19)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
